// File: rtl/mbist_march_ctrl.sv
//-----------------------------------------------------------------------------
// mbist_march_ctrl
//
// March C- sequencer for one MBIST memory port. Drives the address generator
// (run / updown / load), issues one SRAM op per cycle with the March data
// background, compares read data one cycle later and keeps sticky status.
//
// March C- elements (index : direction : ops):
//   E0 up (w0)   E1 up (r0,w1)   E2 up (r1,w0)
//   E3 dn (r0,w1) E4 dn (r1,w0)  E5 up (r0)
//
// Configuration macro:
//   MBIST_CHECKERBOARD_EN  defined   : value 0 = 0x55..55, value 1 = 0xAA..AA
//                          undefined : value 0 = 0x00..00, value 1 = 0xFF..FF
//
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous reset, active low
//   bist_en         in   level start; 0 aborts to IDLE
//   last_addr       in   generator is at the final address for its direction
//   bist_addr       in   current generator address
//   bist_run        out  generator advance enable
//   bist_updown     out  generator direction (1 = up)
//   bist_load       out  generator reload with start address
//   mem_cs          out  SRAM chip select
//   mem_we          out  SRAM write enable (1 = write)
//   mem_wdata       out  SRAM write data
//   mem_rdata       in   SRAM read data, valid one cycle after a read strobe
//   bist_done       out  test complete, held until bist_en drops
//   bist_error      out  sticky mismatch flag
//   bist_error_addr out  address of the first mismatch
//   bist_error_cnt  out  mismatch count, saturating at 15
//-----------------------------------------------------------------------------
module mbist_march_ctrl #(
   parameter int BIST_ADDR_WD = 9,
   parameter int BIST_DATA_WD = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bist_en,
   input  logic                    last_addr,
   input  logic [BIST_ADDR_WD-1:0] bist_addr,
   output logic                    bist_run,
   output logic                    bist_updown,
   output logic                    bist_load,
   output logic                    mem_cs,
   output logic                    mem_we,
   output logic [BIST_DATA_WD-1:0] mem_wdata,
   input  logic [BIST_DATA_WD-1:0] mem_rdata,
   output logic                    bist_done,
   output logic                    bist_error,
   output logic [BIST_ADDR_WD-1:0] bist_error_addr,
   output logic [3:0]              bist_error_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      FLUSH,
      DONE
   } state_t;

   localparam logic [2:0] ELEM_FIRST = 3'd0;
   localparam logic [2:0] ELEM_LAST  = 3'd5;

   //--------------------------------------------------------------------------
   // March element table
   //--------------------------------------------------------------------------
   // E3 and E4 are the only descending elements.
   function automatic logic elem_dir_up(input logic [2:0] e);
      return !((e == 3'd3) || (e == 3'd4));
   endfunction

   // E0 and E5 have a single op; all others have two (read then write).
   function automatic logic elem_single_op(input logic [2:0] e);
      return (e == ELEM_FIRST) || (e == ELEM_LAST);
   endfunction

   // Data value expected by the read of E1..E4 (r1 in E2/E4, r0 otherwise).
   function automatic logic elem_read_value(input logic [2:0] e);
      return (e == 3'd2) || (e == 3'd4);
   endfunction

   //--------------------------------------------------------------------------
   // Data background
   //--------------------------------------------------------------------------
   logic [BIST_DATA_WD-1:0] bg_zero;
   logic [BIST_DATA_WD-1:0] bg_one;

   genvar gi;
   generate
      for (gi = 0; gi < BIST_DATA_WD; gi++) begin : g_bg
`ifdef MBIST_CHECKERBOARD_EN
         // {N{2'b01}}: even bits set for value 0
         assign bg_zero[gi] = ((gi % 2) == 0) ? 1'b1 : 1'b0;
`else
         assign bg_zero[gi] = 1'b0;
`endif
      end
   endgenerate

   assign bg_one = ~bg_zero;

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   state_t                  state_q,    state_d;
   logic [2:0]              elem_q,     elem_d;
   logic                    op_q,       op_d;

   // Compare pipeline: one read in flight at most.
   logic                    rd_vld_q,   rd_vld_d;
   logic [BIST_DATA_WD-1:0] exp_q,      exp_d;
   logic [BIST_ADDR_WD-1:0] cmp_addr_q, cmp_addr_d;

   // Sticky status
   logic                    err_q,      err_d;
   logic [BIST_ADDR_WD-1:0] err_addr_q, err_addr_d;
   logic [3:0]              err_cnt_q,  err_cnt_d;

   //--------------------------------------------------------------------------
   // Decode of the current op from element / op index
   //--------------------------------------------------------------------------
   logic                    in_run;
   logic                    cur_dir_up;
   logic                    cur_last_op;
   logic                    cur_is_write;
   logic                    cur_value;
   logic                    wrap_ok;
   logic [BIST_DATA_WD-1:0] cur_pattern;

   always_comb begin
      in_run       = (state_q == RUN);
      cur_dir_up   = elem_dir_up(elem_q);
      cur_last_op  = elem_single_op(elem_q) ? 1'b1 : op_q;
      // E0 is write-only; in two-op elements the second op is the write.
      cur_is_write = (elem_q == ELEM_FIRST) || op_q;
      if (elem_single_op(elem_q)) begin
         cur_value = 1'b0;
      end else begin
         cur_value = op_q ? ~elem_read_value(elem_q) : elem_read_value(elem_q);
      end
      // At the final address the generator may only wrap if the next element
      // keeps the same direction; on a direction change the address must hold
      // so the new element starts from the same end.
      wrap_ok      = (elem_q != ELEM_LAST) &&
                     (elem_dir_up(elem_q + 3'd1) == cur_dir_up);
      cur_pattern  = cur_value ? bg_one : bg_zero;
   end

   //--------------------------------------------------------------------------
   // Outputs: decodes of registered state (last_addr only gates bist_run)
   //--------------------------------------------------------------------------
   assign mem_cs          = in_run;
   assign mem_we          = in_run && cur_is_write;
   assign mem_wdata       = (in_run && cur_is_write) ? cur_pattern : '0;
   assign bist_run        = in_run && cur_last_op && (!last_addr || wrap_ok);
   assign bist_updown     = cur_dir_up;
   assign bist_load       = (state_q == LOAD);
   assign bist_done       = (state_q == DONE);
   assign bist_error      = err_q;
   assign bist_error_addr = err_addr_q;
   assign bist_error_cnt  = err_cnt_q;

   //--------------------------------------------------------------------------
   // Sequencer next state
   //--------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      op_d    = op_q;

      case (state_q)
         IDLE: begin
            // Park on E0 so the generator loads in the up direction.
            elem_d = ELEM_FIRST;
            op_d   = 1'b0;
            if (bist_en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            elem_d  = ELEM_FIRST;
            op_d    = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            if (!cur_last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (last_addr) begin
                  if (elem_q == ELEM_LAST) begin
                     state_d = FLUSH;
                  end else begin
                     elem_d = elem_q + 3'd1;
                  end
               end
            end
         end
         FLUSH: begin
            // Lets the final read reach the comparator before DONE.
            state_d = DONE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort from any state; status is left untouched.
      if (!bist_en) begin
         state_d = IDLE;
      end
   end

   //--------------------------------------------------------------------------
   // Compare pipeline and status next state
   //--------------------------------------------------------------------------
   always_comb begin
      rd_vld_d   = 1'b0;
      exp_d      = exp_q;
      cmp_addr_d = cmp_addr_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;

      // Capture expectation for a read issued this cycle; dropping bist_en
      // empties the pipeline so nothing is compared after an abort.
      if (bist_en && in_run && !cur_is_write) begin
         rd_vld_d   = 1'b1;
         exp_d      = cur_pattern;
         cmp_addr_d = bist_addr;
      end

      if (state_q == LOAD) begin
         err_d      = 1'b0;
         err_addr_d = '0;
         err_cnt_d  = 4'd0;
      end else if (bist_en && rd_vld_q && (mem_rdata != exp_q)) begin
         err_d = 1'b1;
         if (!err_q) begin
            err_addr_d = cmp_addr_q;
         end
         if (err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         elem_q     <= ELEM_FIRST;
         op_q       <= 1'b0;
         rd_vld_q   <= 1'b0;
         exp_q      <= '0;
         cmp_addr_q <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
         err_cnt_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         elem_q     <= elem_d;
         op_q       <= op_d;
         rd_vld_q   <= rd_vld_d;
         exp_q      <= exp_d;
         cmp_addr_q <= cmp_addr_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
//-----------------------------------------------------------------------------
// tb_mbist_march_ctrl
//
// Surrounds the sequencer with a behavioural address generator and an SRAM
// with injectable read faults. Each March run is predicted by walking the
// March C- element table over a model memory, producing the expected op
// stream and the expected error status.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

`ifdef MBIST_CHECKERBOARD_EN
   localparam int DW = 8;
`else
   localparam int DW = 32;
`endif
   localparam int AW = 9;

   logic          clk;
   logic          rst_n;
   logic          bist_en;
   logic          last_addr;
   logic [AW-1:0] bist_addr;
   logic          bist_run;
   logic          bist_updown;
   logic          bist_load;
   logic          mem_cs;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          bist_done;
   logic          bist_error;
   logic [AW-1:0] bist_error_addr;
   logic [3:0]    bist_error_cnt;

   int asserts = 0;
   int fails   = 0;

   mbist_march_ctrl #(
      .BIST_ADDR_WD (AW),
      .BIST_DATA_WD (DW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bist_en         (bist_en),
      .last_addr       (last_addr),
      .bist_addr       (bist_addr),
      .bist_run        (bist_run),
      .bist_updown     (bist_updown),
      .bist_load       (bist_load),
      .mem_cs          (mem_cs),
      .mem_we          (mem_we),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .bist_done       (bist_done),
      .bist_error      (bist_error),
      .bist_error_addr (bist_error_addr),
      .bist_error_cnt  (bist_error_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   //--------------------------------------------------------------------------
   // Data background as defined for the build
   //--------------------------------------------------------------------------
   function automatic logic [DW-1:0] bg(input bit v);
      logic [DW-1:0] p;
`ifdef MBIST_CHECKERBOARD_EN
      for (int i = 0; i < DW; i++) p[i] = ((i % 2) == 0);
`else
      p = '0;
`endif
      return v ? ~p : p;
   endfunction

   //--------------------------------------------------------------------------
   // Address generator over range 0..n_addr-1
   //--------------------------------------------------------------------------
   int unsigned   n_addr = 4;
   logic [AW-1:0] top_addr;
   assign top_addr  = AW'(n_addr - 1);
   assign last_addr = bist_updown ? (bist_addr == top_addr) : (bist_addr == '0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bist_addr <= '0;
      end else if (bist_load) begin
         bist_addr <= bist_updown ? '0 : top_addr;
      end else if (bist_run) begin
         if (bist_updown) bist_addr <= (bist_addr == top_addr) ? '0 : bist_addr + 1'b1;
         else             bist_addr <= (bist_addr == '0) ? top_addr : bist_addr - 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // SRAM with read-side fault injection
   //   mode 0 none, 1 stuck bit at fault_addr, 2 invert every read,
   //   3 invert reads at fault_addr
   //--------------------------------------------------------------------------
   logic [DW-1:0] sram [0:(1<<AW)-1];
   int fault_mode = 0;
   int fault_addr = 0;
   int fault_bit  = 0;
   bit fault_val  = 1'b0;

   function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] d, input int a);
      logic [DW-1:0] r;
      r = d;
      case (fault_mode)
         1: if (a == fault_addr) r[fault_bit] = fault_val;
         2: r = ~d;
         3: if (a == fault_addr) r = ~d;
         default: ;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (mem_cs && mem_we)  sram[bist_addr] <= mem_wdata;
      if (mem_cs && !mem_we) mem_rdata <= apply_fault(sram[bist_addr], int'(bist_addr));
   end

   //--------------------------------------------------------------------------
   // Reference model: March C- walked element by element
   //--------------------------------------------------------------------------
   typedef struct {
      int            addr;
      bit            we;
      logic [DW-1:0] data;
   } op_t;

   op_t exp_ops[$];
   int  m_err_cnt;
   bit  m_err;
   int  m_err_addr;

   // op codes: 0 = r0, 1 = r1, 2 = w0, 3 = w1
   int el_nops [6]    = '{1, 2, 2, 2, 2, 1};
   bit el_up   [6]    = '{1, 1, 1, 0, 0, 1};
   int el_op   [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

   task automatic build_model(input int n);
      logic [DW-1:0] mm [0:(1<<AW)-1];
      exp_ops.delete();
      m_err_cnt  = 0;
      m_err      = 1'b0;
      m_err_addr = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < n; k++) begin
            int a;
            a = el_up[e] ? k : (n - 1 - k);
            for (int o = 0; o < el_nops[e]; o++) begin
               int            code;
               logic [DW-1:0] want;
               op_t           op;
               code    = el_op[e][o];
               want    = bg((code % 2) == 1);
               op.addr = a;
               op.we   = (code >= 2);
               op.data = op.we ? want : '0;
               exp_ops.push_back(op);
               if (op.we) begin
                  mm[a] = want;
               end else if (apply_fault(mm[a], a) != want) begin
                  if (!m_err) m_err_addr = a;
                  m_err = 1'b1;
                  if (m_err_cnt < 15) m_err_cnt++;
               end
            end
         end
      end
   endtask

   //--------------------------------------------------------------------------
   // One full March run, checked op by op against the model
   //--------------------------------------------------------------------------
   task automatic run_march(input int n, input string tag);
      int  cyc, cs_cycles, last_cs, done_cyc;
      op_t op;
      n_addr = n;
      build_model(n);
      @(negedge clk);
      bist_en = 1'b1;
      @(negedge clk);
      asserts++;
      if (bist_load !== 1'b1 || mem_cs !== 1'b0) begin
         fails++;
         $display("FAIL %s load_cycle: load=%b cs=%b, required load=1 cs=0", tag, bist_load, mem_cs);
      end
      cyc = 0; cs_cycles = 0; last_cs = -1; done_cyc = -1;
      while (cyc < 2000 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         if (mem_cs === 1'b1) begin
            if (cs_cycles == 0) begin
               asserts++;
               if (cyc != 1) begin
                  fails++;
                  $display("FAIL %s first_op_latency: op at cycle %0d after load, required 1", tag, cyc);
               end
            end
            cs_cycles++;
            last_cs = cyc;
            asserts++;
            if (exp_ops.size() == 0) begin
               fails++;
               $display("FAIL %s extra_op: addr=%0d we=%b, required no op", tag, bist_addr, mem_we);
            end else begin
               op = exp_ops.pop_front();
               if (int'(bist_addr) != op.addr || mem_we !== op.we ||
                   (op.we && mem_wdata !== op.data)) begin
                  fails++;
                  $display("FAIL %s op_%0d: addr=%0d we=%b wdata=%h, required addr=%0d we=%b wdata=%h",
                           tag, cs_cycles - 1, bist_addr, mem_we, mem_wdata, op.addr, op.we, op.data);
               end
            end
         end
         if (bist_done === 1'b1) done_cyc = cyc;
      end
      asserts++;
      if (done_cyc < 0) begin
         fails++;
         $display("FAIL %s done_timeout: no done in %0d cycles, required done", tag, cyc);
      end
      asserts++;
      if (cs_cycles != 10 * n || exp_ops.size() != 0) begin
         fails++;
         $display("FAIL %s run_length: %0d ops (%0d unissued), required %0d", tag, cs_cycles, exp_ops.size(), 10 * n);
      end
      asserts++;
      if (done_cyc - last_cs != 2) begin
         fails++;
         $display("FAIL %s done_latency: %0d cycles after last op, required 2", tag, done_cyc - last_cs);
      end
      asserts++;
      if (bist_error !== m_err || int'(bist_error_addr) != m_err_addr || int'(bist_error_cnt) != m_err_cnt) begin
         fails++;
         $display("FAIL %s status: err=%b addr=%0d cnt=%0d, required err=%b addr=%0d cnt=%0d",
                  tag, bist_error, bist_error_addr, bist_error_cnt, m_err, m_err_addr, m_err_cnt);
      end
      @(negedge clk);
      asserts++;
      if (bist_done !== 1'b1 || mem_cs !== 1'b0) begin
         fails++;
         $display("FAIL %s done_hold: done=%b cs=%b, required done=1 cs=0", tag, bist_done, mem_cs);
      end
      bist_en = 1'b0;
      @(negedge clk);
      asserts++;
      if (bist_done !== 1'b0 || bist_error !== m_err || int'(bist_error_cnt) != m_err_cnt) begin
         fails++;
         $display("FAIL %s exit_idle: done=%b err=%b cnt=%0d, required done=0 err=%b cnt=%0d",
                  tag, bist_done, bist_error, bist_error_cnt, m_err, m_err_cnt);
      end
      $display("run %s: n=%0d mode=%0d ops=%0d err=%b addr=%0d cnt=%0d", tag, n, fault_mode,
               cs_cycles, bist_error, bist_error_addr, bist_error_cnt);
   endtask

   //--------------------------------------------------------------------------
   // Scenarios
   //--------------------------------------------------------------------------
   task automatic test_reset();
      rst_n   = 1'b0;
      bist_en = 1'b0;
      repeat (2) @(negedge clk);
      asserts++;
      if ({bist_run, bist_updown, bist_load, mem_cs, mem_we, bist_done, bist_error} !== 7'b0100000) begin
         fails++;
         $display("FAIL reset_ctrl: run,updown,load,cs,we,done,err=%b, required 0100000",
                  {bist_run, bist_updown, bist_load, mem_cs, mem_we, bist_done, bist_error});
      end
      asserts++;
      if (mem_wdata !== '0 || bist_error_addr !== '0 || bist_error_cnt !== 4'd0) begin
         fails++;
         $display("FAIL reset_data: wdata=%h eaddr=%0d cnt=%0d, required 0 0 0", mem_wdata, bist_error_addr, bist_error_cnt);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      asserts++;
      if (mem_cs !== 1'b0 || bist_load !== 1'b0 || bist_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: cs=%b load=%b done=%b, required 0 0 0", mem_cs, bist_load, bist_done);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_fault_free();
      fault_mode = 0;
      run_march(4, "fault_free");
      asserts++;
      if (bist_error !== 1'b0) begin
         fails++;
         $display("FAIL fault_free_err: err=%b, required 0", bist_error);
      end
   endtask

   task automatic test_stuck_at();
      fault_mode = 1; fault_addr = 2; fault_bit = 5; fault_val = 1'b0;
      run_march(4, "stuck_at");
      asserts++;
      if (bist_error !== 1'b1 || bist_error_addr !== 9'd2 || bist_error_cnt !== 4'd2) begin
         fails++;
         $display("FAIL stuck_at_status: err=%b addr=%0d cnt=%0d, required err=1 addr=2 cnt=2",
                  bist_error, bist_error_addr, bist_error_cnt);
      end
   endtask

   task automatic test_saturate();
      fault_mode = 2;
      run_march(16, "saturate");
      asserts++;
      if (bist_error !== 1'b1 || bist_error_addr !== 9'd0 || bist_error_cnt !== 4'd15) begin
         fails++;
         $display("FAIL saturate_status: err=%b addr=%0d cnt=%0d, required err=1 addr=0 cnt=15",
                  bist_error, bist_error_addr, bist_error_cnt);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int n;
         n          = int'($urandom_range(2, 16));
         fault_mode = int'($urandom_range(0, 3));
         fault_addr = int'($urandom_range(0, n - 1));
         fault_bit  = int'($urandom_range(0, DW - 1));
         fault_val  = 1'($urandom_range(0, 1));
         run_march(n, $sformatf("random_%0d", it));
      end
   endtask

   task automatic test_abort();
      int cyc, cs_cycles;
      n_addr = 4; fault_mode = 3; fault_addr = 1;
      @(negedge clk);
      bist_en = 1'b1;
      cyc = 0; cs_cycles = 0;
      // 23 ops observed puts the sequencer inside E3 (ops 20..27 for N = 4)
      while (cs_cycles < 23 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_cs === 1'b1) cs_cycles++;
      end
      asserts++;
      if (cs_cycles < 23) begin
         fails++;
         $display("FAIL abort_reach_e3: %0d ops, required 23", cs_cycles);
      end
      bist_en = 1'b0;
      @(negedge clk);
      asserts++;
      if (mem_cs !== 1'b0 || bist_load !== 1'b0 || bist_done !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: cs=%b load=%b done=%b, required 0 0 0", mem_cs, bist_load, bist_done);
      end
      // E1 r0 and E2 r1 at address 1 both failed before the abort
      asserts++;
      if (bist_error !== 1'b1 || bist_error_addr !== 9'd1 || bist_error_cnt !== 4'd2) begin
         fails++;
         $display("FAIL abort_status_kept: err=%b addr=%0d cnt=%0d, required err=1 addr=1 cnt=2",
                  bist_error, bist_error_addr, bist_error_cnt);
      end
      bist_en = 1'b1;
      @(negedge clk);
      asserts++;
      if (bist_load !== 1'b1 || mem_cs !== 1'b0) begin
         fails++;
         $display("FAIL abort_reload: load=%b cs=%b, required load=1 cs=0", bist_load, mem_cs);
      end
      @(negedge clk);
      asserts++;
      if (mem_cs !== 1'b1 || bist_error !== 1'b0 || bist_error_addr !== '0 || bist_error_cnt !== 4'd0) begin
         fails++;
         $display("FAIL abort_cleared: cs=%b err=%b addr=%0d cnt=%0d, required cs=1 err=0 addr=0 cnt=0",
                  mem_cs, bist_error, bist_error_addr, bist_error_cnt);
      end
      bist_en = 1'b0;
      repeat (2) @(negedge clk);
      $display("abort: dropped after %0d ops, restart checked", cs_cycles);
   endtask

   task automatic test_reset_midrun();
      int cyc, cs_cycles;
      n_addr = 8; fault_mode = 2;
      @(negedge clk);
      bist_en = 1'b1;
      cyc = 0; cs_cycles = 0;
      while (cs_cycles < 30 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_cs === 1'b1) cs_cycles++;
      end
      asserts++;
      if (bist_error !== 1'b1 || mem_cs !== 1'b1) begin
         fails++;
         $display("FAIL midrun_pre: err=%b cs=%b, required err=1 cs=1", bist_error, mem_cs);
      end
      rst_n = 1'b0;
      #1;
      asserts++;
      if ({bist_run, bist_updown, bist_load, mem_cs, mem_we, bist_done, bist_error} !== 7'b0100000) begin
         fails++;
         $display("FAIL midrun_reset_ctrl: run,updown,load,cs,we,done,err=%b, required 0100000",
                  {bist_run, bist_updown, bist_load, mem_cs, mem_we, bist_done, bist_error});
      end
      asserts++;
      if (mem_wdata !== '0 || bist_error_addr !== '0 || bist_error_cnt !== 4'd0) begin
         fails++;
         $display("FAIL midrun_reset_data: wdata=%h eaddr=%0d cnt=%0d, required 0 0 0",
                  mem_wdata, bist_error_addr, bist_error_cnt);
      end
      @(negedge clk);
      bist_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset_midrun: asynchronous reset after %0d ops checked", cs_cycles);
   endtask

   initial begin
      test_reset();
      test_fault_free();
      test_stuck_at();
      test_saturate();
      test_random();
      test_abort();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
